// File: rtl/pll_lock_sequencer.sv
// Sequences PLL RESETB and a qualified system reset from a synchronised PLL lock,
// retrying the PLL on lock timeout and counting retries and lock-loss events.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W               = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock_async,
    input  logic       clear_counts,
    output logic       pll_resetb,
    output logic       sys_resetn,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count,
    output logic [7:0] retry_count
);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_resetb_q, sys_resetn_q, ready_q;
    logic [7:0]       loss_q, loss_d, retry_q, retry_d;
    logic             loss_inc, retry_inc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        loss_inc  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = PLL_RESET;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                end
            end
            STABILIZE: begin
                // Any low sample restarts qualification from WAIT_LOCK.
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d  = PLL_RESET;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear wins over a same-edge increment; both saturate at 255.
    always_comb begin
        loss_d  = loss_q;
        retry_d = retry_q;
        if (clear_counts) begin
            loss_d  = '0;
            retry_d = '0;
        end else begin
            if (loss_inc && loss_q != 8'hFF)   loss_d  = loss_q + 8'd1;
            if (retry_inc && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= PLL_RESET;
            cnt_q        <= '0;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            loss_q       <= '0;
            retry_q      <= '0;
        end else begin
            lock_meta_q  <= pll_lock_async;
            lock_s_q     <= lock_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // Outputs decoded from next state so they change on the same edge as state.
            pll_resetb_q <= (state_d != PLL_RESET);
            sys_resetn_q <= (state_d == RUN);
            ready_q      <= (state_d == RUN);
            loss_q       <= loss_d;
            retry_q      <= retry_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign sys_resetn      = sys_resetn_q;
    assign ready           = ready_q;
    assign state           = state_q;
    assign lock_loss_count = loss_q;
    assign retry_count     = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters (4/8/32);
// outputs are sampled on the falling edge.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       lock = 1'b0;
    logic       clear_counts = 1'b0;
    logic       pll_resetb, sys_resetn, ready;
    logic [1:0] state;
    logic [7:0] loss, retry;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .CNT_W(16)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_lock_async(lock), .clear_counts(clear_counts),
        .pll_resetb(pll_resetb), .sys_resetn(sys_resetn), .ready(ready), .state(state),
        .lock_loss_count(loss), .retry_count(retry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (!ready && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int max, output int n);
        n = 0;
        while (state != s && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic lose_and_relock(input string tag);
        int n;
        lock = 1'b0;
        wait_state(2'd0, 10, n);
        check({tag, "_loss_lat"}, n, 3);
        lock = 1'b1;
        wait_ready(100, n);
        check({tag, "_relock"}, state, 3);
    endtask

    initial begin
        int n, lowcnt;

        // Reset state, asserted asynchronously before any clock edge
        #1 resetn = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_pll_resetb", pll_resetb, 0);
        check("rst_ready", ready, 0);
        check("rst_sys_resetn", sys_resetn, 0);
        check("rst_counts", {loss, retry}, 0);
        @(negedge clk);
        resetn = 1'b1;

        // First PLL_RESET lasts exactly 4 edges, then lock-to-ready is 11 edges
        n = 0;
        while (!pll_resetb && n < 20) begin tick(); n++; end
        check("first_reset_len", n, 4);
        check("wait_lock_state", state, 1);
        lock = 1'b1;
        wait_ready(100, n);
        check("lock_to_ready", n, 11);
        check("run_state", state, 3);
        check("run_sys_resetn", sys_resetn, 1);
        check("run_counts", {loss, retry}, 0);

        // Lock drop of 3 cycles in RUN
        lock = 1'b0;
        tick(); tick();
        check("drop_ready_e1", ready, 1);
        tick();
        check("drop_ready_e2", ready, 0);
        check("drop_sys_resetn", sys_resetn, 0);
        check("drop_state", state, 0);
        check("drop_loss_cnt", loss, 1);
        lock = 1'b1;
        lowcnt = 0;
        repeat (8) begin
            if (!pll_resetb) lowcnt++;
            tick();
        end
        check("drop_pll_low_len", lowcnt, 4);
        wait_ready(100, n);
        check("drop_relock_lat", n, 5);

        // One-cycle lock glitch at the 5th STABILIZE cycle
        lock = 1'b0;
        wait_state(2'd0, 10, n);
        lock = 1'b1;
        wait_state(2'd2, 50, n);
        check("glitch_enter_stab", state, 2);
        repeat (4) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        tick();
        check("glitch_ready_a1", ready, 0);
        tick();
        check("glitch_back_wait", state, 1);
        check("glitch_ready_a2", ready, 0);
        tick();
        check("glitch_restab", state, 2);
        wait_ready(100, n);
        check("glitch_requal", n, 8);
        check("glitch_counts", {loss, retry}, {8'd2, 8'd0});

        // Clear on the same edge as a lock-loss increment from 5
        repeat (3) lose_and_relock("loss");
        check("loss_is_5", loss, 5);
        lock = 1'b0;
        tick(); tick();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        check("clr_state", state, 0);
        check("clr_priority", loss, 0);
        lock = 1'b1;
        wait_ready(100, n);
        check("clr_relock", state, 3);

        // Lock held low: 4 low + 32 high per retry period
        lock = 1'b0;
        wait_state(2'd0, 10, n);
        for (int k = 1; k <= 7; k++) begin
            n = 0;
            while (!pll_resetb && n < 50) begin tick(); n++; end
            if (k == 1 || k == 7) check("retry_low_len", n, 4);
            n = 0;
            while (pll_resetb && n < 50) begin tick(); n++; end
            if (k == 1 || k == 7) check("retry_high_len", n, 32);
            check("retry_cnt", retry, k);
        end
        lock = 1'b1;
        wait_ready(100, n);
        check("retry_relock", state, 3);
        repeat (2) lose_and_relock("loss2");
        check("pre_rst_counts", {loss, retry}, {8'd3, 8'd7});

        // Asynchronous reset mid-RUN, lock stays high
        #2 resetn = 1'b0;
        #1;
        check("arst_ready", ready, 0);
        check("arst_sys_resetn", sys_resetn, 0);
        check("arst_pll_resetb", pll_resetb, 0);
        check("arst_state", state, 0);
        check("arst_counts", {loss, retry}, 0);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (!pll_resetb && n < 20) begin tick(); n++; end
        check("arst_reset_len", n, 4);
        wait_ready(100, n);
        check("arst_ready_lat", n, 9);

        // Retry counter saturation
        lock = 1'b0;
        wait_state(2'd0, 10, n);
        repeat (300 * 36 + 40) tick();
        check("retry_sat", retry, 255);
        check("loss_after_sat", loss, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
